// File: rtl/gate_ctrl_param_pkg.sv
// Shared definitions for the parametrised parking-gate controller.
//   state_t        one-hot FSM state codes (5 bits)
//   DEFAULT_PIN    factory PIN value (8 bits)
//   gate_out_t     bundle of the four gate/annunciator commands
//   decode_outputs Moore output decode for a given state
package gate_ctrl_param_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_WAIT_PIN = 5'b00010,
    ST_OPEN     = 5'b00100,
    ST_ALARM    = 5'b01000,
    ST_BLOCK    = 5'b10000
  } state_t;

  localparam logic [7:0] DEFAULT_PIN = 8'b0011_0101;

  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
  } gate_out_t;

  // Gate is closed in every state except OPEN; alarm and block are
  // tied to their own states, so they can never be active together.
  function automatic gate_out_t decode_outputs(input state_t s);
    gate_out_t o;
    o.cerrado = 1'b1;
    o.abierto = 1'b0;
    o.alarma  = 1'b0;
    o.bloqueo = 1'b0;
    case (s)
      ST_OPEN: begin
        o.cerrado = 1'b0;
        o.abierto = 1'b1;
      end
      ST_ALARM: o.alarma  = 1'b1;
      ST_BLOCK: o.bloqueo = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gate_ctrl_param_try_counter.sv
// Saturating counter of consecutive wrong-PIN attempts.
//   Clk, Reset  clock / asynchronous active-high reset
//   inc         count one wrong attempt (holds at MAX)
//   clr         clear the count (wins over inc)
//   count       current attempt count
//   last_try    one more wrong attempt reaches MAX
module gate_ctrl_param_try_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last_try
);

  assign last_try = (count == W'(MAX - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gate_ctrl_param.sv
// PIN-authenticated parking entry gate controller with retry limit,
// exposed attempt count and tailgate blocking.
//   Clk       clock, rising edge
//   Reset     asynchronous, active-high reset
//   Pin       PIN value, sampled only with enterPin
//   enterPin  one-cycle PIN-entry strobe
//   Vehiculo  vehicle present at the entrance sensor
//   Termino   vehicle has cleared the gate
//   Cerrado   gate closed command       Abierto  gate open command
//   Alarma    wrong-PIN alarm           Bloqueo  tailgate block
//   Intentos  consecutive wrong-PIN count, saturating at MAX_TRIES
// Build option: GATE_CTRL_TIMEOUT_EN adds a WAIT_PIN inactivity timer that
// counts as a wrong attempt every TIMEOUT_CYC cycles without enterPin.
//
// state    | meaning
// IDLE     | gate closed, waiting for a vehicle
// WAIT_PIN | vehicle present, waiting for a PIN
// OPEN     | correct PIN accepted, gate open
// ALARM    | MAX_TRIES wrong PINs, only a correct PIN clears it
// BLOCK    | second vehicle behind the first, correct PIN releases
module gate_ctrl_param
  import gate_ctrl_param_pkg::*;
#(
  parameter int               PIN_W       = 8,
  parameter logic [PIN_W-1:0] PIN_VALUE   = PIN_W'(DEFAULT_PIN),
  parameter int               MAX_TRIES   = 3,
  parameter int               TIMEOUT_CYC = 16,
  localparam int              TRY_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PIN_W-1:0] Pin,
  input  logic             enterPin,
  input  logic             Vehiculo,
  input  logic             Termino,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [TRY_W-1:0] Intentos
);

  if (MAX_TRIES < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("gate_ctrl_param: MAX_TRIES and TIMEOUT_CYC must be >= 1");
  end

  state_t    state, state_next;
  gate_out_t out_q;
  logic      pin_ok, good_pin, wrong_try, timeout, last_try;

  assign pin_ok   = (Pin == PIN_VALUE);
  assign good_pin = enterPin && pin_ok;

  // Wrong attempts only count while a PIN is being asked for; in BLOCK a
  // wrong PIN is ignored entirely.
  assign wrong_try = ((state == ST_WAIT_PIN) && ((enterPin && !pin_ok) || timeout))
                  || ((state == ST_ALARM) && enterPin && !pin_ok);

`ifdef GATE_CTRL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer;

  // Only fires when the cycle would otherwise stay in WAIT_PIN, so a
  // PIN entry or the vehicle leaving always takes precedence.
  assign timeout = (state == ST_WAIT_PIN) && !enterPin && Vehiculo
                && (timer == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer <= '0;
    end else if ((state != ST_WAIT_PIN) || enterPin || !Vehiculo || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  gate_ctrl_param_try_counter #(
    .MAX (MAX_TRIES),
    .W   (TRY_W)
  ) u_try_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (wrong_try),
    .clr      (good_pin && ((state == ST_WAIT_PIN) || (state == ST_ALARM))),
    .count    (Intentos),
    .last_try (last_try)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (Vehiculo) state_next = ST_WAIT_PIN;
      ST_WAIT_PIN: begin
        if (good_pin)                  state_next = ST_OPEN;
        else if (wrong_try)            state_next = last_try ? ST_ALARM : ST_WAIT_PIN;
        else if (!enterPin && !Vehiculo) state_next = ST_IDLE;
      end
      ST_ALARM:    if (good_pin) state_next = ST_OPEN;
      ST_OPEN:     if (Termino)  state_next = Vehiculo ? ST_BLOCK : ST_IDLE;
      ST_BLOCK:    if (good_pin) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      out_q <= decode_outputs(ST_IDLE);
    end else begin
      state <= state_next;
      out_q <= decode_outputs(state_next);
    end
  end

  assign Cerrado = out_q.cerrado;
  assign Abierto = out_q.abierto;
  assign Alarma  = out_q.alarma;
  assign Bloqueo = out_q.bloqueo;

endmodule

// File: tb/tb_gate_ctrl_param.sv
module tb_gate_ctrl_param;

  localparam int         PIN_W = 8;
  localparam logic [7:0] PIN_OK = 8'b0011_0101;
  localparam int         MAXT  = 3;
  localparam int         TOUT  = 16;
`ifdef GATE_CTRL_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_WAIT = 1, M_OPEN = 2, M_ALARM = 3, M_BLOCK = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Pin = 8'h00;
  logic       enterPin = 1'b0, Vehiculo = 1'b0, Termino = 1'b0;
  logic       Cerrado, Abierto, Alarma, Bloqueo;
  logic [1:0] Intentos;

  int checks = 0;
  int errors = 0;
  int m_mode, m_tries, m_idle;

  always #5 Clk = ~Clk;

  gate_ctrl_param #(
    .PIN_W       (PIN_W),
    .PIN_VALUE   (PIN_OK),
    .MAX_TRIES   (MAXT),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Pin      (Pin),
    .enterPin (enterPin),
    .Vehiculo (Vehiculo),
    .Termino  (Termino),
    .Cerrado  (Cerrado),
    .Abierto  (Abierto),
    .Alarma   (Alarma),
    .Bloqueo  (Bloqueo),
    .Intentos (Intentos)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_cerrado"},  int'(Cerrado),  int'(m_mode != M_OPEN));
    chk({tag, "_abierto"},  int'(Abierto),  int'(m_mode == M_OPEN));
    chk({tag, "_alarma"},   int'(Alarma),   int'(m_mode == M_ALARM));
    chk({tag, "_bloqueo"},  int'(Bloqueo),  int'(m_mode == M_BLOCK));
    chk({tag, "_intentos"}, int'(Intentos), m_tries);
  endtask

  task automatic model_wrong();
    if (m_tries < MAXT) m_tries++;
    if (m_tries == MAXT) m_mode = M_ALARM;
  endtask

  task automatic model_step(input logic [7:0] p, input logic ep, input logic v, input logic t);
    bit ok;
    ok = (p == PIN_OK);
    case (m_mode)
      M_IDLE: if (v) m_mode = M_WAIT;
      M_WAIT: begin
        if (ep) begin
          m_idle = 0;
          if (ok) begin m_mode = M_OPEN; m_tries = 0; end
          else model_wrong();
        end else if (!v) begin
          m_mode = M_IDLE;
        end else if (TOUT_EN) begin
          m_idle++;
          if (m_idle == TOUT) begin m_idle = 0; model_wrong(); end
        end
      end
      M_ALARM: if (ep) begin
        if (ok) begin m_mode = M_OPEN; m_tries = 0; end
        else model_wrong();
      end
      M_OPEN: if (t) m_mode = v ? M_BLOCK : M_IDLE;
      M_BLOCK: if (ep && ok) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    if (m_mode != M_WAIT) m_idle = 0;
  endtask

  task automatic step(input string tag, input logic [7:0] p, input logic ep,
                      input logic v, input logic t);
    @(negedge Clk);
    Pin = p; enterPin = ep; Vehiculo = v; Termino = t;
    @(posedge Clk);
    model_step(p, ep, v, t);
    #1;
    check_all(tag);
  endtask

  // Reset is asserted between edges; the outputs must react without a clock.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    enterPin = 1'b0; Vehiculo = 1'b0; Termino = 1'b0;
    m_mode = M_IDLE; m_tries = 0; m_idle = 0;
    #1;
    check_all(tag);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    m_mode = M_IDLE; m_tries = 0; m_idle = 0;
    do_reset("reset");

    // correct PIN opens, vehicle leaves, gate closes
    step("arrive",    8'h00,  1'b0, 1'b1, 1'b0);
    step("pin_ok",    PIN_OK, 1'b1, 1'b1, 1'b0);
    chk("open_direct", int'(Abierto), 1);
    step("cleared",   8'h00,  1'b0, 1'b0, 1'b1);
    chk("closed_direct", int'(Cerrado), 1);

    // three wrong PINs raise the alarm, correct PIN clears it
    step("arrive2",   8'h00,  1'b0, 1'b1, 1'b0);
    step("wrong1",    8'h00,  1'b1, 1'b1, 1'b0);
    step("wrong2",    8'h00,  1'b1, 1'b1, 1'b0);
    step("wrong3",    8'h00,  1'b1, 1'b1, 1'b0);
    chk("alarm_direct", int'(Alarma), 1);
    chk("tries_direct", int'(Intentos), 3);
    step("alarm_wrong", 8'b0011_0100, 1'b1, 1'b0, 1'b0);
    step("alarm_noveh", 8'h00,  1'b0, 1'b0, 1'b0);
    step("alarm_ok",  PIN_OK, 1'b1, 1'b1, 1'b0);

    // tailgate block: wrong PIN ignored, correct PIN releases to IDLE
    step("tailgate",  8'h00,  1'b0, 1'b1, 1'b1);
    chk("block_direct", int'(Bloqueo), 1);
    step("blk_wrong", 8'hFF,  1'b1, 1'b1, 1'b0);
    step("blk_ok",    PIN_OK, 1'b1, 1'b1, 1'b0);

    // count survives leaving WAIT_PIN
    step("wait_again", 8'h00, 1'b0, 1'b1, 1'b0);
    step("r_wrong1",  8'h35 ^ 8'h80, 1'b1, 1'b1, 1'b0);
    step("r_wrong2",  8'h00,  1'b1, 1'b1, 1'b0);
    step("r_leave",   8'h00,  1'b0, 1'b0, 1'b0);
    step("r_back",    8'h00,  1'b0, 1'b1, 1'b0);
    step("r_wrong3",  8'h00,  1'b1, 1'b1, 1'b0);
    chk("retained_alarm", int'(Alarma), 1);

    // enterPin beats Vehiculo=0 in the same cycle
    step("prio_ok",   PIN_OK, 1'b1, 1'b0, 1'b0);
    step("open_hold", 8'h00,  1'b0, 1'b1, 1'b0);

    // reset mid-OPEN
    do_reset("reset_open");
    step("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef GATE_CTRL_TIMEOUT_EN
    step("to_arrive", 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3 * TOUT; i++) step("to_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    chk("timeout_tries", int'(Intentos), 3);
    chk("timeout_alarm", int'(Alarma), 1);
    do_reset("reset_to");
`endif

    for (int i = 0; i < 600; i++) begin
      logic [7:0] p;
      logic ep, v, t;
      case ($urandom_range(0, 2))
        0:       p = PIN_OK;
        1:       p = 8'h00;
        default: p = 8'($urandom);
      endcase
      ep = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
      else step("rnd", p, ep, v, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
